bus_requester: RTL and testbench
================================

Name: bus_requester

Overview:
Requester-side agent for the shared priority bus. It accepts one burst command from local logic, raises a single request line toward the central arbiter, and waits for its one-hot grant bit. It then drives address/data beats onto the bus. It tolerates preemption by higher-priority masters, enforces a grant-wait timeout, and releases the request when the burst finishes. One instance sits in front of each bus controller (TIC, ONE, TWO, ARM).

Parameters:
ADDR_W, 8, bus address width
DATA_W, 8, bus data width
MAX_BURST, 4, maximum beats per command (power of two, >=2)
LEN_W, $clog2(MAX_BURST), width of command length field
TIMEOUT, 16, maximum consecutive cycles in REQ without grant before abort (>=2)

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  reset
i_cmd_valid  in  1  command offered
o_cmd_ready  out  1  command accepted when valid&ready
i_cmd_addr  in  ADDR_W  burst base address
i_cmd_len  in  LEN_W  beats minus one (0 = 1 beat)
i_wr_valid  in  1  write beat data available
i_wr_data  in  DATA_W  write beat data
o_wr_ready  out  1  beat consumed when valid&ready
o_req  out  1  request to arbiter (this master's bit)
i_gnt  in  1  this master's bit of the arbiter grant vector
o_bus_en  out  1  bus beat valid
o_bus_addr  out  ADDR_W  bus beat address
o_bus_data  out  DATA_W  bus beat data
o_done  out  1  one-cycle pulse, burst completed
o_err  out  1  one-cycle pulse, burst aborted on timeout
o_busy  out  1  high in any state other than IDLE

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset: state IDLE, o_req=0, o_bus_en=0, o_bus_addr=0, o_bus_data=0, o_done=0, o_err=0, o_busy=0. Internal address, remaining-beat and timeout counters are cleared. o_cmd_ready and o_wr_ready are 0 while i_rst=1. Reset mid-burst abandons the burst with no o_done or o_err pulse.
- States: IDLE, REQ, XFER, RELEASE.
- IDLE: o_cmd_ready=1 (combinational). On i_cmd_valid=1: latch addr and len into internal counters; beats_left=len+1; go REQ. o_req is registered high starting the next cycle.
- REQ: o_req=1, and the wait counter increments each cycle.
  - If i_gnt=1, go XFER.
  - Else, if the wait counter reaches TIMEOUT-1, go IDLE. o_req drops, o_err pulses for one cycle, and the remaining beats are discarded.
  - The wait counter clears on every entry to REQ.
- XFER: o_req=1, and o_wr_ready = (state==XFER && i_gnt) combinationally.
  - Beat accepted (i_wr_valid & o_wr_ready): next cycle o_bus_en=1, o_bus_addr=current addr, o_bus_data=i_wr_data. Addr then increments modulo 2^ADDR_W (wraps, no carry out), and beats_left decrements.
  - Cycles with no accepted beat: o_bus_en=0. Address and data hold their last values.
  - If the accepted beat is the last one (beats_left==1), go RELEASE.
  - If i_gnt=0 (preemption), go REQ with o_req still high and the remaining beats kept. No beat is consumed that cycle.
- RELEASE: o_req=0, o_done=1, and the last beat is visible on the bus this cycle. Next state is IDLE.
- o_req is never high in IDLE or RELEASE. o_bus_en is high for exactly len+1 cycles per completed burst.
- Latency: command to o_req is 1 cycle. Grant (in REQ) to first o_wr_ready is 1 cycle. Beat accept to o_bus_en is 1 cycle.
- Simultaneous events:
  - Timeout and grant in the same REQ cycle: grant wins.
  - Grant loss and i_wr_valid in the same XFER cycle: no beat is accepted.
  - i_cmd_valid while not in IDLE is ignored (o_cmd_ready=0).
- o_err and o_done are never high together.

Test Plan:
1. Reset, cmd addr=0x10 len=3, i_gnt high 2 cycles after o_req, i_wr_valid always high with data A0..A3 -> o_bus_en 4 consecutive cycles, addr 0x10..0x13, data A0..A3; o_done pulses once; o_req low in RELEASE.
2. cmd addr=0xFE len=3 -> bus addresses 0xFE, 0xFF, 0x00, 0x01 (wrap).
3. i_gnt never asserted -> o_req high exactly TIMEOUT cycles, then o_err single pulse; o_bus_en never high; o_cmd_ready=1 the following cycle.
4. len=3, drop i_gnt for 3 cycles after beat 2 -> only 2 beats before the gap; o_req stays high; after re-grant beats 3–4 go to addr base+2, base+3; o_done once.
5. Throttle i_wr_valid (1010 pattern) during XFER -> o_bus_en only on cycles after accepted beats; data order preserved; total beats = len+1.
6. Assert i_rst during beat 2 of 4 -> next cycle all outputs 0, state IDLE, no o_done or o_err; a new command then completes normally.

Source files
------------

// File: rtl/bus_requester.sv
// rtl/bus_requester.sv - requester agent for the shared priority bus
// Takes one burst command, requests the bus, streams beats while granted, releases on completion.
module bus_requester #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int LEN_W     = $clog2(MAX_BURST),
  parameter int TIMEOUT   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic              o_req,
  input  logic              i_gnt,
  output logic              o_bus_en,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_data,
  output logic              o_done,
  output logic              o_err,
  output logic              o_busy
);

  localparam int WAIT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int BEATS_W = LEN_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_RELEASE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [BEATS_W-1:0]  beats_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                req_q, err_q, bus_en_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic [DATA_W-1:0]   bus_data_q;
  logic                beat_acc, timeout_hit, last_beat, cmd_acc;

  assign cmd_acc     = (state_q == S_IDLE) && i_cmd_valid;
  assign beat_acc    = i_wr_valid && o_wr_ready;
  assign timeout_hit = (wait_q == WAIT_W'(TIMEOUT - 1));
  assign last_beat   = (beats_q == BEATS_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Grant beats timeout in REQ; grant loss beats a pending beat in XFER.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (i_cmd_valid) state_d = S_REQ;
      S_REQ: begin
        if (i_gnt)            state_d = S_XFER;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_XFER: begin
        if (!i_gnt)                     state_d = S_REQ;
        else if (beat_acc && last_beat) state_d = S_RELEASE;
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready = !i_rst && (state_q == S_IDLE);
    o_wr_ready  = !i_rst && (state_q == S_XFER) && i_gnt;
    o_done      = (state_q == S_RELEASE);
    o_busy      = (state_q != S_IDLE);
    o_req       = req_q;
    o_err       = err_q;
    o_bus_en    = bus_en_q;
    o_bus_addr  = bus_addr_q;
    o_bus_data  = bus_data_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q     <= '0;
      beats_q    <= '0;
      wait_q     <= '0;
      req_q      <= 1'b0;
      err_q      <= 1'b0;
      bus_en_q   <= 1'b0;
      bus_addr_q <= '0;
      bus_data_q <= '0;
    end else begin
      req_q    <= (state_d == S_REQ) || (state_d == S_XFER);
      err_q    <= (state_q == S_REQ) && !i_gnt && timeout_hit;
      bus_en_q <= beat_acc;
      // Counter only runs while parked in REQ, so every entry starts from zero.
      if (state_q == S_REQ) wait_q <= wait_q + WAIT_W'(1);
      else                  wait_q <= '0;
      if (cmd_acc) begin
        addr_q  <= i_cmd_addr;
        beats_q <= {1'b0, i_cmd_len} + BEATS_W'(1);
      end else if (beat_acc) begin
        addr_q  <= addr_q + ADDR_W'(1);
        beats_q <= beats_q - BEATS_W'(1);
      end else if ((state_q == S_REQ) && !i_gnt && timeout_hit) begin
        beats_q <= '0;
      end
      if (beat_acc) begin
        bus_addr_q <= addr_q;
        bus_data_q <= i_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_bus_requester.sv
// tb/tb_bus_requester.sv - directed self-checking bench for bus_requester
module tb_bus_requester;

  logic       i_clk = 1'b0;
  logic       i_rst, i_cmd_valid, i_wr_valid, i_gnt;
  logic [7:0] i_cmd_addr, i_wr_data;
  logic [1:0] i_cmd_len;
  logic       o_cmd_ready, o_wr_ready, o_req, o_bus_en, o_done, o_err, o_busy;
  logic [7:0] o_bus_addr, o_bus_data;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] q_addr[$];
  logic [7:0] q_data[$];
  int done_cnt, err_cnt, req_cnt, en_rise, viol;
  logic prev_en = 1'b0;

  bus_requester dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
    .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
    .o_req(o_req), .i_gnt(i_gnt),
    .o_bus_en(o_bus_en), .o_bus_addr(o_bus_addr), .o_bus_data(o_bus_data),
    .o_done(o_done), .o_err(o_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_bus_en) begin
      q_addr.push_back(o_bus_addr);
      q_data.push_back(o_bus_data);
    end
    if (o_bus_en && !prev_en) en_rise++;
    prev_en = o_bus_en;
    if (o_done) done_cnt++;
    if (o_err) err_cnt++;
    if (o_req) req_cnt++;
    if ((o_done && o_req) || (o_done && o_err)) viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    done_cnt = 0; err_cnt = 0; req_cnt = 0; en_rise = 0; viol = 0;
  endtask

  task automatic send_cmd(input logic [7:0] a, input logic [1:0] l);
    i_cmd_addr = a; i_cmd_len = l; i_cmd_valid = 1'b1;
    #1;
    check("cmd_ready_idle", o_cmd_ready, 1);
    step();
    i_cmd_valid = 1'b0;
    check("req_after_cmd", o_req, 1);
  endtask

  task automatic burst(input logic [7:0] a, input logic [1:0] l, input int gnt_dly,
                       input int drop_after, input int drop_len, input bit throttle,
                       input logic [7:0] base, input int exp_runs);
    int beats, gap_left;
    bit gap_done, tog, finished;
    logic [7:0] ea;
    beats = 0; gap_left = 0; gap_done = 0; tog = 1; finished = 0;
    clear_log();
    send_cmd(a, l);
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      if (!gap_done && drop_after >= 0 && beats == drop_after) begin
        gap_left = drop_len;
        gap_done = 1;
      end
      i_gnt = (cyc >= gnt_dly) && (gap_left == 0);
      i_wr_valid = throttle ? tog : 1'b1;
      i_wr_data = base + 8'(beats);
      #1;
      if (gap_left > 0) check("req_held_preempt", o_req, 1);
      if (gap_left == 1) check("beats_before_gap", q_addr.size(), drop_after);
      if (i_wr_valid && o_wr_ready) beats++;
      step();
      if (gap_left > 0) gap_left--;
      tog = ~tog;
      if (o_done) begin
        finished = 1;
        check("req_low_release", o_req, 0);
        check("err_low_release", o_err, 0);
      end
    end
    check("burst_completed", finished, 1);
    i_gnt = 1'b0; i_wr_valid = 1'b0;
    step();
    check("busy_after_burst", o_busy, 0);
    check("beat_count", q_addr.size(), 32'(l) + 1);
    for (int i = 0; i < q_addr.size(); i++) begin
      ea = a + 8'(i);
      check($sformatf("beat%0d_addr", i), q_addr[i], ea);
      check($sformatf("beat%0d_data", i), q_data[i], base + 8'(i));
    end
    check("done_once", done_cnt, 1);
    check("no_err", err_cnt, 0);
    check("en_runs", en_rise, exp_runs);
    check("no_overlap", viol, 0);
  endtask

  initial begin
    i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_addr = '0; i_cmd_len = '0;
    i_wr_valid = 1'b0; i_wr_data = '0; i_gnt = 1'b0;
    step(); step();
    check("rst_req", o_req, 0);
    check("rst_bus_en", o_bus_en, 0);
    check("rst_bus_addr", o_bus_addr, 0);
    check("rst_bus_data", o_bus_data, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_busy", o_busy, 0);
    check("rst_cmd_ready", o_cmd_ready, 0);
    check("rst_wr_ready", o_wr_ready, 0);
    i_rst = 1'b0;
    step();

    // 1: basic burst, grant two cycles after request
    burst(8'h10, 2'd3, 2, -1, 0, 1'b0, 8'hA0, 1);
    // 2: address wrap
    burst(8'hFE, 2'd3, 0, -1, 0, 1'b0, 8'hB0, 1);

    // 3: grant never arrives
    begin
      bit seen;
      seen = 0;
      clear_log();
      send_cmd(8'h55, 2'd1);
      for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
        step();
        if (o_err) seen = 1;
      end
      check("timeout_err_seen", seen, 1);
      check("timeout_req_low", o_req, 0);
      check("timeout_cmd_ready", o_cmd_ready, 1);
      step();
      check("timeout_cmd_ready_next", o_cmd_ready, 1);
      check("timeout_err_pulse", o_err, 0);
      step();
      check("timeout_req_cycles", req_cnt, 16);
      check("timeout_err_once", err_cnt, 1);
      check("timeout_no_beats", q_addr.size(), 0);
      check("timeout_no_done", done_cnt, 0);
    end

    // 4: preemption for three cycles after beat 2
    burst(8'h20, 2'd3, 1, 2, 3, 1'b0, 8'hC0, 2);
    // 5: throttled write data, 1010
    burst(8'h30, 2'd3, 0, -1, 0, 1'b1, 8'hD0, 4);

    // 6: reset while beat 2 is being accepted
    begin
      int beats;
      bit hit;
      beats = 0; hit = 0;
      clear_log();
      send_cmd(8'h40, 2'd3);
      i_gnt = 1'b1; i_wr_valid = 1'b1;
      for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
        i_wr_data = 8'hE0 + 8'(beats);
        #1;
        if (o_wr_ready) begin
          if (beats == 1) begin
            i_rst = 1'b1;
            hit = 1;
          end
          beats++;
        end
        step();
      end
      check("rst_mid_reached", hit, 1);
      check("rstm_req", o_req, 0);
      check("rstm_bus_en", o_bus_en, 0);
      check("rstm_bus_addr", o_bus_addr, 0);
      check("rstm_bus_data", o_bus_data, 0);
      check("rstm_busy", o_busy, 0);
      check("rstm_done", o_done, 0);
      check("rstm_err", o_err, 0);
      check("rstm_wr_ready", o_wr_ready, 0);
      i_rst = 1'b0; i_gnt = 1'b0; i_wr_valid = 1'b0;
      step();
      check("rstm_cmd_ready", o_cmd_ready, 1);
      step();
      check("rstm_no_done", done_cnt, 0);
      check("rstm_no_err", err_cnt, 0);
      check("rstm_one_beat", q_addr.size(), 1);
    end
    burst(8'h80, 2'd2, 1, -1, 0, 1'b0, 8'hF0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
